// File: rtl/multiplicador_pkg.sv
// multiplicador_pkg: FSM state encoding and default operand width shared by the multiplier
package multiplicador_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/multiplicador.sv
// multiplicador: sequential unsigned shift-and-add multiplier with valid/done/ack handshake
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   a, b       WIDTH-bit unsigned multiplicand / multiplier, sampled on the start edge
//   valid_data start request, taken only in IDLE
//   ack        result consumed, taken only in DONE
//   producto   registered 2*WIDTH-bit product, held until the next completion
//   Done_Flag  high in DONE, result valid
//   koala      high in CALC, multiplication in progress
module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_data,
  input  logic                 ack,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 Done_Flag,
  output logic                 koala
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_next;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0] mlt;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    acc_next = acc + (mlt[0] ? mcand : '0);
    last = cnt == CW'(WIDTH - 1);
    state_next = state == IDLE ? (valid_data ? CALC : IDLE) :
                 state == CALC ? (last ? DONE : CALC) :
                 (ack ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // latency is fixed: every CALC edge is one iteration, the WIDTH-th one lands the result
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mcand <= '0;
      mlt <= '0;
      acc <= '0;
      cnt <= '0;
      producto <= '0;
    end else if (state == IDLE && valid_data) begin
      mcand <= {{WIDTH{1'b0}}, a};
      mlt <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= acc_next;
      mcand <= mcand << 1;
      mlt <= mlt >> 1;
      cnt <= cnt + CW'(1);
      if (last) producto <= acc_next;
    end
  assign koala = state == CALC;
  assign Done_Flag = state == DONE;
endmodule

// File: tb/tb_multiplicador.sv
// tb_multiplicador: directed and random checks of multiplicador latency, handshake and reset
module tb_multiplicador;
  logic clk = 0, reset = 0, valid_data = 0, ack = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] producto;
  logic Done_Flag, koala;
  int checks = 0, errors = 0;
  multiplicador dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_data(valid_data), .ack(ack),
    .producto(producto), .Done_Flag(Done_Flag), .koala(koala)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // entered #1 after an edge with the DUT idle; leaves it idle the same way
  task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp);
    logic [63:0] prev;
    int n;
    prev = producto;
    a = x;
    b = y;
    valid_data = 1;
    @(posedge clk);
    #1;
    valid_data = 0;
    a = ~x;
    b = ~y;
    check({tag, " busy"}, 64'(koala), 64'd1);
    check({tag, " held"}, producto, prev);
    n = 0;
    while (!Done_Flag && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd32);
    check({tag, " product"}, producto, exp);
    check({tag, " idle"}, 64'(koala), 64'd0);
    ack = 1;
    @(posedge clk);
    #1;
    ack = 0;
    check({tag, " ack"}, 64'(Done_Flag), 64'd0);
  endtask
  initial begin
    logic [31:0] x, y;
    #10;
    check("rst producto", producto, 64'd0);
    check("rst done", 64'(Done_Flag), 64'd0);
    check("rst koala", 64'(koala), 64'd0);
    #10 reset = 1;
    @(posedge clk);
    #1;
    mul("32x3", 32'd32, 32'd3, 64'd96);
    mul("5x5", 32'd5, 32'd5, 64'd25);
    mul("0xmax", 32'd0, 32'hFFFF_FFFF, 64'd0);
    mul("maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    a = 32'd9;
    b = 32'd11;
    valid_data = 1;
    @(posedge clk);
    #1;
    valid_data = 0;
    repeat (32) @(posedge clk);
    #1;
    check("hold done", 64'(Done_Flag), 64'd1);
    for (int i = 0; i < 50; i++) begin
      a = 32'(i * 13);
      b = 32'(i * 7 + 1);
      @(posedge clk);
      #1;
      check("hold flag", 64'(Done_Flag), 64'd1);
      check("hold value", producto, 64'd99);
      check("hold no start", 64'(koala), 64'd0);
    end
    ack = 1;
    @(posedge clk);
    #1;
    ack = 0;
    check("hold ack", 64'(Done_Flag), 64'd0);
    a = 32'd100;
    b = 32'd100;
    valid_data = 1;
    @(posedge clk);
    #1;
    valid_data = 0;
    repeat (9) @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("abort koala", 64'(koala), 64'd0);
    check("abort done", 64'(Done_Flag), 64'd0);
    check("abort producto", producto, 64'd0);
    @(posedge clk);
    #1;
    reset = 1;
    check("abort idle", 64'(koala), 64'd0);
    mul("7x6", 32'd7, 32'd6, 64'd42);
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      mul("rnd", x, y, {32'd0, x} * {32'd0, y});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
